mem_port_arbiter_3x1: RTL and testbench

//   Round-robin arbiter that shares one 32-bit memory port between three requesters
//   (0: instruction fetch, 1: load/store unit, 2: CSR/debug access).
//   It generates the 2-bit select for the existing 3:1 address/data mux in the parent,

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/rr_pick_3.sv | 30 +++
 rtl/mem_port_arbiter_3x1.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter_3x1.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the 3-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int NUM_REQ = 3;

  typedef logic [1:0] arb_sel_t;

  localparam arb_sel_t SEL_REQ0 = 2'b00;
  localparam arb_sel_t SEL_REQ1 = 2'b01;
  localparam arb_sel_t SEL_REQ2 = 2'b10;

  function automatic logic [NUM_REQ-1:0] sel_onehot(arb_sel_t s);
    case (s)
      SEL_REQ0: return 3'b001;
      SEL_REQ1: return 3'b010;
      SEL_REQ2: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  // Successor modulo 3; the unused code 11 folds back to requester 0.
  function automatic arb_sel_t sel_next(arb_sel_t s);
    case (s)
      SEL_REQ0: return SEL_REQ1;
      SEL_REQ1: return SEL_REQ2;
      default:  return SEL_REQ0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick_3.sv
// Combinational round-robin pick: first set request searching ptr, ptr+1, ptr+2 (mod 3).
module rr_pick_3
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  arb_sel_t           ptr,
  output logic               valid,
  output arb_sel_t           idx
);

  arb_sel_t o0;
  arb_sel_t o1;
  arb_sel_t o2;

  always_comb begin
    o0    = (ptr == 2'b11) ? SEL_REQ0 : ptr;
    o1    = sel_next(o0);
    o2    = sel_next(o1);
    valid = |req;
    idx   = SEL_REQ0;
    if ((req & sel_onehot(o0)) != '0) begin
      idx = o0;
    end else if ((req & sel_onehot(o1)) != '0) begin
      idx = o1;
    end else if ((req & sel_onehot(o2)) != '0) begin
      idx = o2;
    end
  end

endmodule

// File: rtl/mem_port_arbiter_3x1.sv
// Round-robin owner of the shared memory port: grants one requester, holds it until
// mem_ack or timeout, then returns to IDLE for one cycle before the next grant.
module mem_port_arbiter_3x1
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic [1:0]         sel,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic               busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t         state_q, state_d;
  arb_sel_t           ptr_q, ptr_d;
  arb_sel_t           sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic     pick_valid;
  arb_sel_t pick_idx;
  logic     timeout;

  rr_pick_3 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Handshake: a requester holds req high until it sees its ack or err pulse; the
  // memory raises mem_ack for one cycle while mem_req is high to complete the access.
  assign busy    = (state_q == ARB_BUSY);
  assign mem_req = busy;
  assign grant   = grant_q;
  assign sel     = sel_q;
  assign timeout = (TIMEOUT_CYCLES > 0) && busy && (cnt_q == TO_LAST);
  assign ack     = rst_n ? (grant_q & {NUM_REQ{busy & mem_ack}}) : '0;
  assign err     = rst_n ? (grant_q & {NUM_REQ{timeout & ~mem_ack}}) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BUSY;
          sel_d   = pick_idx;
          grant_d = sel_onehot(pick_idx);
          cnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        // Requests are not looked at here: a dropped req still waits for ack/timeout.
        if (mem_ack || timeout) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = sel_next(sel_q);
          cnt_d   = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= SEL_REQ0;
      sel_q   <= SEL_REQ0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter_3x1.sv
// Directed bench for mem_port_arbiter_3x1 with a 4-cycle timeout.
module tb_mem_port_arbiter_3x1;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       mem_ack;
  logic       mem_req;
  logic [1:0] sel;
  logic [2:0] grant;
  logic [2:0] ack;
  logic [2:0] err;
  logic       busy;

  int n_cmp;
  int n_mis;

  mem_port_arbiter_3x1 #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .sel     (sel),
    .grant   (grant),
    .ack     (ack),
    .err     (err),
    .busy    (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r_n, input logic [2:0] r, input logic m);
    @(negedge clk);
    rst_n   = r_n;
    req     = r;
    mem_ack = m;
    #1;
  endtask

  task automatic expect_port(input string tag, input logic [2:0] g, input logic [1:0] s,
                             input logic [2:0] a, input logic [2:0] e);
    check_val({tag, ".grant"}, 32'(grant), 32'(g));
    check_val({tag, ".sel"}, 32'(sel), 32'(s));
    check_val({tag, ".ack"}, 32'(ack), 32'(a));
    check_val({tag, ".err"}, 32'(err), 32'(e));
    check_val({tag, ".mem_req"}, 32'(mem_req), 32'(g != 3'b000));
    check_val({tag, ".busy"}, 32'(busy), 32'(g != 3'b000));
  endtask

  task automatic reset_dut();
    drive(1'b0, 3'b000, 1'b0);
    drive(1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    logic [2:0] seq_g [4];
    logic [1:0] seq_s [4];
    n_cmp   = 0;
    n_mis   = 0;
    rst_n   = 1'b0;
    req     = 3'b111;
    mem_ack = 1'b1;

    // 1: reset with everything asserted
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b111, 1'b1);
      expect_port("t1_rst", 3'b000, 2'b00, 3'b000, 3'b000);
    end

    // 2: single request from requester 1, ack in 3rd busy cycle
    drive(1'b1, 3'b010, 1'b0);
    expect_port("t2_idle", 3'b000, 2'b00, 3'b000, 3'b000);
    drive(1'b1, 3'b010, 1'b0);
    expect_port("t2_c1", 3'b010, 2'b01, 3'b000, 3'b000);
    drive(1'b1, 3'b010, 1'b0);
    expect_port("t2_c2", 3'b010, 2'b01, 3'b000, 3'b000);
    drive(1'b1, 3'b010, 1'b1);
    expect_port("t2_c3", 3'b010, 2'b01, 3'b010, 3'b000);
    drive(1'b1, 3'b000, 1'b0);
    expect_port("t2_c4", 3'b000, 2'b01, 3'b000, 3'b000);

    // 3: all requesting, rotation 0,1,2,0 with an IDLE gap each time
    reset_dut();
    seq_g[0] = 3'b001; seq_g[1] = 3'b010; seq_g[2] = 3'b100; seq_g[3] = 3'b001;
    seq_s[0] = 2'b00;  seq_s[1] = 2'b01;  seq_s[2] = 2'b10;  seq_s[3] = 2'b00;
    drive(1'b1, 3'b111, 1'b0);
    expect_port("t3_idle0", 3'b000, 2'b00, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b111, 1'b1);
      expect_port($sformatf("t3_busy%0d", i), seq_g[i], seq_s[i], seq_g[i], 3'b000);
      drive(1'b1, 3'b111, 1'b0);
      expect_port($sformatf("t3_gap%0d", i), 3'b000, seq_s[i], 3'b000, 3'b000);
    end

    // 4a: timeout on requester 2, err in 4th busy cycle
    reset_dut();
    drive(1'b1, 3'b100, 1'b0);
    expect_port("t4_idle", 3'b000, 2'b00, 3'b000, 3'b000);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'b100, 1'b0);
      expect_port($sformatf("t4_c%0d", i), 3'b100, 2'b10, 3'b000, 3'b000);
    end
    drive(1'b1, 3'b100, 1'b0);
    expect_port("t4_to", 3'b100, 2'b10, 3'b000, 3'b100);
    drive(1'b1, 3'b111, 1'b0);
    expect_port("t4_after", 3'b000, 2'b10, 3'b000, 3'b000);
    // ptr wrapped to 0 after the abort
    drive(1'b1, 3'b111, 1'b1);
    expect_port("t4_ptr0", 3'b001, 2'b00, 3'b001, 3'b000);

    // 4b: ack arriving in the timeout cycle wins over err
    drive(1'b1, 3'b100, 1'b0);
    expect_port("t4b_idle", 3'b000, 2'b00, 3'b000, 3'b000);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'b100, 1'b0);
      expect_port($sformatf("t4b_c%0d", i), 3'b100, 2'b10, 3'b000, 3'b000);
    end
    drive(1'b1, 3'b100, 1'b1);
    expect_port("t4b_c4", 3'b100, 2'b10, 3'b100, 3'b000);
    drive(1'b1, 3'b000, 1'b0);
    expect_port("t4b_after", 3'b000, 2'b10, 3'b000, 3'b000);

    // 5: reset mid-transaction suppresses ack and restores ptr=0
    reset_dut();
    drive(1'b1, 3'b001, 1'b0);
    drive(1'b1, 3'b001, 1'b1);
    expect_port("t5_first", 3'b001, 2'b00, 3'b001, 3'b000);
    drive(1'b1, 3'b001, 1'b0);
    drive(1'b1, 3'b001, 1'b0);
    expect_port("t5_busy", 3'b001, 2'b00, 3'b000, 3'b000);
    drive(1'b0, 3'b001, 1'b1);
    check_val("t5_rst.ack", 32'(ack), 32'(3'b000));
    check_val("t5_rst.err", 32'(err), 32'(3'b000));
    drive(1'b1, 3'b011, 1'b0);
    expect_port("t5_idle", 3'b000, 2'b00, 3'b000, 3'b000);
    drive(1'b1, 3'b011, 1'b1);
    expect_port("t5_grant", 3'b001, 2'b00, 3'b001, 3'b000);

    // 6: owner drops req mid-busy; then mem_ack during IDLE is ignored
    drive(1'b1, 3'b001, 1'b0);
    expect_port("t6_idle", 3'b000, 2'b00, 3'b000, 3'b000);
    drive(1'b1, 3'b000, 1'b0);
    expect_port("t6_c1", 3'b001, 2'b00, 3'b000, 3'b000);
    drive(1'b1, 3'b000, 1'b0);
    expect_port("t6_c2", 3'b001, 2'b00, 3'b000, 3'b000);
    drive(1'b1, 3'b000, 1'b1);
    expect_port("t6_c3", 3'b001, 2'b00, 3'b001, 3'b000);
    drive(1'b1, 3'b000, 1'b1);
    expect_port("t6_stray1", 3'b000, 2'b00, 3'b000, 3'b000);
    drive(1'b1, 3'b000, 1'b1);
    expect_port("t6_stray2", 3'b000, 2'b00, 3'b000, 3'b000);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
